// File: rtl/typing_game_ctrl_if.sv
// Typing-game controller bus: key/start pulses in, display values out.
interface typing_game_ctrl_if;
   logic       start;
   logic       key_valid;
   logic [3:0] key;
   logic [3:0] random_num;
   logic [3:0] score;
   logic [3:0] time_left;
   logic       playing;
   logic       game_over;

   // Driver side: pulses in, display values back
   modport master (
      output start,
      output key_valid,
      output key,
      input  random_num,
      input  score,
      input  time_left,
      input  playing,
      input  game_over
   );

   // Controller side
   modport slave (
      input  start,
      input  key_valid,
      input  key,
      output random_num,
      output score,
      output time_left,
      output playing,
      output game_over
   );
endinterface

// File: rtl/typing_game_ctrl.sv
// Typing tutor game controller: picks target digits from a free-running LFSR,
// scores typed keys against the target and runs a per-round seconds countdown.
// All display-facing values come straight from flops.
module typing_game_ctrl #(
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned GAME_SECS     = 15,
   parameter int unsigned MAX_SCORE     = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   typing_game_ctrl_if.slave bus
);

   localparam int unsigned CW        = $clog2(TICKS_PER_SEC);
   localparam logic [CW-1:0] TICK_LAST = CW'(TICKS_PER_SEC - 1);
   localparam logic [3:0]  GAME_SECS_L = 4'(GAME_SECS);
   localparam logic [3:0]  MAX_SCORE_L = 4'(MAX_SCORE);
   localparam logic [7:0]  LFSR_SEED   = 8'hA5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_OVER = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [7:0]    lfsr_q, lfsr_d;
   logic [CW-1:0] sec_cnt_q, sec_cnt_d;
   logic [3:0]    random_num_q, random_num_d;
   logic [3:0]    score_q, score_d;
   logic [3:0]    time_left_q, time_left_d;
   logic          playing_q, playing_d;
   logic          game_over_q, game_over_d;
   logic [3:0]    new_target_s;

   // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
   function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
      logic fb;
      fb = cur[7] ^ cur[5] ^ cur[4] ^ cur[3];
      return {cur[6:0], fb};
   endfunction

   // Fold the low nibble into 0-9 and bump it if it would repeat the target,
   // so every new target is visibly different from the previous one.
   function automatic logic [3:0] next_target(input logic [3:0] nib,
                                              input logic [3:0] prev);
      logic [3:0] cand;
      logic [3:0] res;
      if (nib < 4'd10) begin
         cand = nib;
      end else begin
         cand = nib - 4'd10;
      end
      if (cand == prev) begin
         if (cand == 4'd9) begin
            res = 4'd0;
         end else begin
            res = cand + 4'd1;
         end
      end else begin
         res = cand;
      end
      return res;
   endfunction

   // Candidate target available every cycle from the current LFSR value
   always_comb begin
      new_target_s = next_target(lfsr_q[3:0], random_num_q);
   end

   // Next-state, scoring and countdown logic
   always_comb begin
      state_d      = state_q;
      lfsr_d       = lfsr_step(lfsr_q);
      sec_cnt_d    = sec_cnt_q;
      random_num_d = random_num_q;
      score_d      = score_q;
      time_left_d  = time_left_q;

      case (state_q)
         ST_IDLE, ST_OVER: begin
            // A key arriving together with start is dropped on purpose.
            if (bus.start) begin
               state_d      = ST_PLAY;
               score_d      = 4'd0;
               time_left_d  = GAME_SECS_L;
               sec_cnt_d    = '0;
               random_num_d = new_target_s;
            end else begin
               state_d = state_q;
            end
         end
         ST_PLAY: begin
            // Key is scored first; the final tick below may still end the round.
            if (bus.key_valid) begin
               if (bus.key == random_num_q) begin
                  if (score_q >= MAX_SCORE_L) begin
                     score_d = MAX_SCORE_L;
                  end else begin
                     score_d = score_q + 4'd1;
                  end
                  random_num_d = new_target_s;
               end else begin
                  if (score_q == 4'd0) begin
                     score_d = 4'd0;
                  end else begin
                     score_d = score_q - 4'd1;
                  end
               end
            end else begin
               score_d = score_q;
            end

            if (sec_cnt_q == TICK_LAST) begin
               sec_cnt_d = '0;
               if (time_left_q <= 4'd1) begin
                  time_left_d = 4'd0;
                  state_d     = ST_OVER;
               end else begin
                  time_left_d = time_left_q - 4'd1;
               end
            end else begin
               sec_cnt_d = sec_cnt_q + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      playing_d   = (state_d == ST_PLAY);
      game_over_d = (state_d == ST_OVER);
   end

   // State and datapath registers with asynchronous reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         lfsr_q       <= LFSR_SEED;
         sec_cnt_q    <= '0;
         random_num_q <= 4'd0;
         score_q      <= 4'd0;
         time_left_q  <= GAME_SECS_L;
         playing_q    <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         lfsr_q       <= lfsr_d;
         sec_cnt_q    <= sec_cnt_d;
         random_num_q <= random_num_d;
         score_q      <= score_d;
         time_left_q  <= time_left_d;
         playing_q    <= playing_d;
         game_over_q  <= game_over_d;
      end
   end

   assign bus.random_num = random_num_q;
   assign bus.score      = score_q;
   assign bus.time_left  = time_left_q;
   assign bus.playing    = playing_q;
   assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_typing_game_ctrl.sv
// Directed bench for typing_game_ctrl: one 3-second round instance and one
// 15-second instance for score saturation, both at 4 clocks per second.
module tb_typing_game_ctrl;

   logic clk = 1'b0;
   logic rst_n;

   typing_game_ctrl_if ifa ();
   typing_game_ctrl_if ifb ();

   typing_game_ctrl #(
      .TICKS_PER_SEC(4),
      .GAME_SECS    (3),
      .MAX_SCORE    (9)
   ) dut_a (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifa)
   );

   typing_game_ctrl #(
      .TICKS_PER_SEC(4),
      .GAME_SECS    (15),
      .MAX_SCORE    (9)
   ) dut_b (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (ifb)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start_a();
      ifa.start = 1'b1;
      @(negedge clk);
      ifa.start = 1'b0;
   endtask

   task automatic pulse_key_a(input logic [3:0] k);
      ifa.key       = k;
      ifa.key_valid = 1'b1;
      @(negedge clk);
      ifa.key_valid = 1'b0;
   endtask

   logic [3:0] r_old;
   logic [3:0] w_key;

   initial begin
      rst_n         = 1'b0;
      ifa.start     = 1'b0;
      ifa.key_valid = 1'b0;
      ifa.key       = 4'd0;
      ifb.start     = 1'b0;
      ifb.key_valid = 1'b0;
      ifb.key       = 4'd0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // Idle after reset
      repeat (50) @(negedge clk);
      check_eq("idle_score", ifa.score, 0);
      check_eq("idle_time", ifa.time_left, 3);
      check_eq("idle_rnd", ifa.random_num, 0);
      check_eq("idle_playing", ifa.playing, 0);
      check_eq("idle_over", ifa.game_over, 0);

      // Countdown through a full round
      pulse_start_a();
      check_eq("start_playing", ifa.playing, 1);
      check_eq("start_time", ifa.time_left, 3);
      check_eq("start_rnd_range", int'(ifa.random_num < 4'd10), 1);
      check_eq("start_rnd_new", int'(ifa.random_num != 4'd0), 1);
      repeat (3) @(negedge clk);
      check_eq("cd_t3_hold", ifa.time_left, 3);
      @(negedge clk);
      check_eq("cd_t2", ifa.time_left, 2);
      repeat (4) @(negedge clk);
      check_eq("cd_t1", ifa.time_left, 1);
      repeat (3) @(negedge clk);
      check_eq("cd_t1_hold", ifa.time_left, 1);
      check_eq("cd_not_over", ifa.game_over, 0);
      @(negedge clk);
      check_eq("cd_t0", ifa.time_left, 0);
      check_eq("cd_over", ifa.game_over, 1);
      check_eq("cd_not_playing", ifa.playing, 0);
      r_old = ifa.random_num;
      repeat (20) @(negedge clk);
      check_eq("frz_time", ifa.time_left, 0);
      check_eq("frz_score", ifa.score, 0);
      check_eq("frz_over", ifa.game_over, 1);
      check_eq("frz_rnd", ifa.random_num, r_old);

      // Correct and wrong keys
      pulse_start_a();
      check_eq("rs_playing", ifa.playing, 1);
      check_eq("rs_time", ifa.time_left, 3);
      check_eq("rs_over", ifa.game_over, 0);
      r_old = ifa.random_num;
      pulse_key_a(r_old);
      check_eq("hit_score", ifa.score, 1);
      check_eq("hit_rnd_new", int'(ifa.random_num != r_old), 1);
      check_eq("hit_rnd_range", int'(ifa.random_num < 4'd10), 1);
      r_old = ifa.random_num;
      w_key = (r_old == 4'd9) ? 4'd0 : r_old + 4'd1;
      pulse_key_a(w_key);
      check_eq("miss_score", ifa.score, 0);
      check_eq("miss_rnd_kept", ifa.random_num, r_old);
      pulse_key_a(4'd12);
      check_eq("miss_floor", ifa.score, 0);

      // Correct key coinciding with the final tick
      repeat (30) @(negedge clk);
      check_eq("pre_over", ifa.game_over, 1);
      pulse_start_a();
      repeat (11) @(negedge clk);
      check_eq("ft_t1", ifa.time_left, 1);
      check_eq("ft_score0", ifa.score, 0);
      pulse_key_a(ifa.random_num);
      check_eq("ft_score", ifa.score, 1);
      check_eq("ft_over", ifa.game_over, 1);
      check_eq("ft_time", ifa.time_left, 0);
      check_eq("ft_playing", ifa.playing, 0);
      pulse_start_a();
      check_eq("re_score", ifa.score, 0);
      check_eq("re_time", ifa.time_left, 3);
      check_eq("re_playing", ifa.playing, 1);

      // Asynchronous reset in the middle of a round
      pulse_key_a(ifa.random_num);
      check_eq("mid_score", ifa.score, 1);
      #2 rst_n = 1'b0;
      #1;
      check_eq("ar_score", ifa.score, 0);
      check_eq("ar_time", ifa.time_left, 3);
      check_eq("ar_rnd", ifa.random_num, 0);
      check_eq("ar_playing", ifa.playing, 0);
      check_eq("ar_over", ifa.game_over, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Key in IDLE ignored
      pulse_key_a(4'd0);
      check_eq("idle_key_score", ifa.score, 0);
      check_eq("idle_key_playing", ifa.playing, 0);
      check_eq("idle_key_rnd", ifa.random_num, 0);

      // Start inside PLAY must not restart the second counter
      pulse_start_a();
      r_old = ifa.random_num;
      pulse_start_a();
      check_eq("sip_playing", ifa.playing, 1);
      check_eq("sip_rnd", ifa.random_num, r_old);
      repeat (3) @(negedge clk);
      check_eq("sip_time", ifa.time_left, 2);

      // Saturation on the 15-second instance
      check_eq("b_idle_time", ifb.time_left, 15);
      ifb.start = 1'b1;
      @(negedge clk);
      ifb.start = 1'b0;
      check_eq("b_playing", ifb.playing, 1);
      for (int i = 0; i < 10; i++) begin
         ifb.key       = ifb.random_num;
         ifb.key_valid = 1'b1;
         @(negedge clk);
         ifb.key_valid = 1'b0;
         check_eq($sformatf("b_sat_%0d", i), ifb.score, (i + 1 > 9) ? 9 : i + 1);
         check_eq($sformatf("b_rng_%0d", i), int'(ifb.random_num < 4'd10), 1);
         @(negedge clk);
      end
      check_eq("b_still_playing", ifb.playing, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
